// File: rtl/mult_accum_stage.sv
// Dot-product accumulator placed after a fixed-latency 16x16 multiplier wrapper.
// Optional build macro MULT_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module mult_accum_stage #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LAT    = 2,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              op_ready,
  input  logic              op_valid,
  input  logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic              drop_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   retired_q, retired_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               drop_q, drop_d;
  logic [LAT-1:0]     vld_q, vld_d;
  logic [LAT:0]       vld_ext;
  logic [ACC_W:0]     sum;
  logic               issue;
  logic               tap;

  // Returns {carry, next accumulator}; the carry bit doubles as the overflow flag.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0]  acc,
                                             input logic [PROD_W-1:0] prod);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W+1-PROD_W){1'b0}}, prod};
`ifdef MULT_ACC_SAT_EN
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
`endif
    return s;
  endfunction

  assign op_ready  = (state_q == S_ACCUM) && (issued_q < len_q);
  assign issue     = op_valid & op_ready;
  assign tap       = vld_q[LAT-1];
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign result    = acc_q;
  assign overflow  = ovf_q;
  assign drop_err  = drop_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    sum       = '0;
    // The delay line mirrors the wrapper latency; its tail marks a tracked product.
    vld_ext   = {vld_q, issue};
    vld_d     = vld_ext[LAT-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = len;
          issued_d  = '0;
          retired_d = '0;
          acc_d     = '0;
          ovf_d     = 1'b0;
          drop_d    = 1'b0;
          state_d   = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (issue) issued_d = issued_q + 1'b1;
        if (tap) begin
          sum       = acc_add(acc_q, product);
          acc_d     = sum[ACC_W-1:0];
          ovf_d     = ovf_q | sum[ACC_W];
          retired_d = retired_q + 1'b1;
          if (retired_d == len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (tap && (state_q != S_ACCUM)) drop_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      vld_q     <= vld_d;
    end
  end

endmodule

// File: tb/tb_mult_accum_stage.sv
// Directed bench for mult_accum_stage: a 2-stage multiplier model feeds two instances (ACC_W 40 and 33).
module tb_mult_accum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        op_valid;
  logic        res_ready;
  logic [15:0] a, b;
  logic [31:0] p1, product;

  logic        op_ready, busy, res_valid, overflow, drop_err;
  logic [39:0] result;
  logic        op_ready33, busy33, res_valid33, overflow33, drop_err33;
  logic [32:0] result33;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Registered multiplier wrapper model, latency 2, no reset (in-flight values survive rst).
  always_ff @(posedge clk) begin
    p1      <= a * b;
    product <= p1;
  end

  mult_accum_stage #(.PROD_W(32), .ACC_W(40), .LAT(2), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .op_ready(op_ready),
    .op_valid(op_valid), .product(product), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .overflow(overflow), .drop_err(drop_err)
  );

  mult_accum_stage #(.PROD_W(32), .ACC_W(33), .LAT(2), .LEN_W(8)) dut33 (
    .clk(clk), .rst(rst), .start(start), .len(len), .op_ready(op_ready33),
    .op_valid(op_valid), .product(product), .busy(busy33), .res_valid(res_valid33),
    .res_ready(res_ready), .result(result33), .overflow(overflow33), .drop_err(drop_err33)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [15:0] x, input logic [15:0] y);
    chk(tag, op_ready, 1'b1);
    op_valid = 1'b1;
    a = x;
    b = y;
    tick();
    op_valid = 1'b0;
    a = '0;
    b = '0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !res_valid; i++) tick();
    chk(tag, res_valid, 1'b1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  localparam logic [63:0] BIG   = 64'd4294836225;
  localparam logic [63:0] SUM3  = 64'd12884508675;
`ifdef MULT_ACC_SAT_EN
  localparam logic [63:0] EXP33 = 64'd8589934591;
`else
  localparam logic [63:0] EXP33 = 64'd4294574083;
`endif

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_op_ready", op_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_result", result, 40'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop_err", drop_err, 1'b0);
    rst = 1'b0;
    tick();

    // len=3, back-to-back, result valid LAT+1 cycles after last issue
    chk("t1_ready_pre_start", op_ready, 1'b0);
    start_run(8'd3);
    issue("t1_rdy0", 16'd2, 16'd3);
    issue("t1_rdy1", 16'd4, 16'd5);
    issue("t1_rdy2", 16'hFFFF, 16'hFFFF);
    chk("t1_ready_after_last", op_ready, 1'b0);
    chk("t1_rv_c1", res_valid, 1'b0);
    tick();
    chk("t1_rv_c2", res_valid, 1'b0);
    tick();
    chk("t1_rv_c3", res_valid, 1'b1);
    chk("t1_result", result, 64'd4294836251);
    chk("t1_overflow", overflow, 1'b0);
    chk("t1_drop_err", drop_err, 1'b0);
    handshake();
    chk("t1_rv_after_hs", res_valid, 1'b0);
    chk("t1_result_hold", result, 64'd4294836251);

    // len=0, plus start coinciding with the DONE handshake
    start_run(8'd0);
    chk("t2_rv", res_valid, 1'b1);
    chk("t2_result", result, 40'd0);
    chk("t2_op_ready", op_ready, 1'b0);
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    chk("t2_start_in_done_busy", busy, 1'b0);
    chk("t2_start_in_done_rv", res_valid, 1'b0);
    tick();
    chk("t2_start_next_rv", res_valid, 1'b1);
    start = 1'b0;
    tick();
    chk("t2_rv_one_cycle", res_valid, 1'b0);
    res_ready = 1'b0;

    // Overflow at ACC_W=33; the 40-bit instance must not overflow
    start_run(8'd3);
    for (int i = 0; i < 3; i++) issue("t3_rdy", 16'hFFFF, 16'hFFFF);
    wait_done("t3_done");
    chk("t3_result40", result, SUM3);
    chk("t3_overflow40", overflow, 1'b0);
    chk("t3_rv33", res_valid33, 1'b1);
    chk("t3_result33", result33, EXP33);
    chk("t3_overflow33", overflow33, 1'b1);
    handshake();
    chk("t3_overflow_hold", overflow33, 1'b1);

    // len=4 with gaps 0,2,1 and consumer stall
    start_run(8'd4);
    issue("t4_rdy0", 16'd1, 16'd2);
    issue("t4_rdy1", 16'd3, 16'd4);
    tick();
    tick();
    issue("t4_rdy2", 16'd5, 16'd6);
    tick();
    issue("t4_rdy3", 16'd100, 16'd200);
    chk("t4_ready_after_4th", op_ready, 1'b0);
    wait_done("t4_done");
    for (int i = 0; i < 5; i++) begin
      chk("t4_rv_stall", res_valid, 1'b1);
      chk("t4_result_stall", result, 40'd20044);
      tick();
    end
    handshake();
    chk("t4_rv_after_hs", res_valid, 1'b0);

    // Asynchronous reset mid-run, then a clean len=1 run
    start_run(8'd5);
    issue("t5_rdy0", 16'd1, 16'd1);
    rst = 1'b1;
    #1;
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_result", result, 40'd0);
    tick();
    rst = 1'b0;
    tick();
    start_run(8'd1);
    issue("t5_rdy1", 16'd7, 16'd9);
    wait_done("t5_done");
    chk("t5_result", result, 40'd63);
    chk("t5_drop_err", drop_err, 1'b0);
    handshake();

    // start ignored in ACCUM; op_valid ignored while op_ready=0
    start_run(8'd2);
    start = 1'b1;
    len = 8'd9;
    tick();
    start = 1'b0;
    issue("t6_rdy0", 16'd2, 16'd2);
    issue("t6_rdy1", 16'd3, 16'd3);
    op_valid = 1'b1;
    a = 16'd1000;
    b = 16'd1000;
    for (int i = 0; i < 3 && !res_valid; i++) begin
      chk("t6_ready_low", op_ready, 1'b0);
      tick();
    end
    op_valid = 1'b0;
    a = '0;
    b = '0;
    wait_done("t6_done");
    chk("t6_result", result, 40'd13);
    chk("t6_drop_err", drop_err, 1'b0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
